// File: rtl/pmem_loader.sv
// Program-memory loader: parses a length-prefixed, checksummed byte stream,
// writes big-endian 16-bit words to program memory and releases the CPU reset.
module pmem_loader #(
  parameter int PMEM_ADDR_WIDTH = 12,
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int PMEM_NUM_WORDS  = 2048,
  parameter int PC_INCREMENT    = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_byte_valid,
  input  logic [7:0]                 in_byte,
  input  logic                       in_reload,
  output logic                       out_byte_ready,
  output logic                       out_pmem_wr_en,
  output logic [PMEM_ADDR_WIDTH-1:0] out_pmem_wr_addr,
  output logic [PMEM_WORD_WIDTH-1:0] out_pmem_wr_word,
  output logic                       out_cpu_reset,
  output logic                       out_done,
  output logic                       out_error
);

  localparam int CW = PMEM_ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state;
  logic [7:0]    len_hi;
  logic [7:0]    data_hi;
  logic [7:0]    sum;
  logic [CW-1:0] len;
  logic [CW-1:0] word_cnt;
  logic [15:0]   len_full;
  logic          accept;

  assign accept   = in_byte_valid && out_byte_ready;
  assign len_full = {len_hi, in_byte};

  // Byte address of a word index; wraps at the program-memory size.
  function automatic logic [PMEM_ADDR_WIDTH-1:0] word_addr(input logic [CW-1:0] cnt);
    return PMEM_ADDR_WIDTH'(cnt * CW'(PC_INCREMENT));
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= S_LEN_HI;
      out_byte_ready   <= 1'b0;
      out_pmem_wr_en   <= 1'b0;
      out_pmem_wr_addr <= '0;
      out_pmem_wr_word <= '0;
      out_cpu_reset    <= 1'b1;
      out_done         <= 1'b0;
      out_error        <= 1'b0;
      sum              <= 8'd0;
      word_cnt         <= '0;
      len              <= '0;
      len_hi           <= 8'd0;
      data_hi          <= 8'd0;
    end else begin
      out_pmem_wr_en <= 1'b0;
      case (state)
        S_LEN_HI: begin
          out_byte_ready <= 1'b1;
          if (accept) begin
            len_hi <= in_byte;
            sum    <= sum + in_byte;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: if (accept) begin
          sum <= sum + in_byte;
          len <= len_full[CW-1:0];
          if (len_full > 16'(PMEM_NUM_WORDS)) begin
            state          <= S_ERROR;
            out_error      <= 1'b1;
            out_byte_ready <= 1'b0;
          end else if (len_full == 16'd0) begin
            state <= S_CHK;
          end else begin
            state <= S_DATA_HI;
          end
        end
        S_DATA_HI: if (accept) begin
          data_hi <= in_byte;
          sum     <= sum + in_byte;
          state   <= S_DATA_LO;
        end
        S_DATA_LO: if (accept) begin
          sum              <= sum + in_byte;
          out_pmem_wr_en   <= 1'b1;
          out_pmem_wr_addr <= word_addr(word_cnt);
          out_pmem_wr_word <= PMEM_WORD_WIDTH'({data_hi, in_byte});
          word_cnt         <= word_cnt + 1'b1;
          state            <= (word_cnt + 1'b1 == len) ? S_CHK : S_DATA_HI;
        end
        S_CHK: if (accept) begin
          out_byte_ready <= 1'b0;
          if (in_byte == sum) begin
            state         <= S_DONE;
            out_done      <= 1'b1;
            out_cpu_reset <= 1'b0;
          end else begin
            state     <= S_ERROR;
            out_error <= 1'b1;
          end
        end
        S_DONE, S_ERROR: if (in_reload) begin
          // Restart without a byte; the CPU goes back into reset immediately.
          state          <= S_LEN_HI;
          out_byte_ready <= 1'b1;
          out_cpu_reset  <= 1'b1;
          out_done       <= 1'b0;
          out_error      <= 1'b0;
          sum            <= 8'd0;
          word_cnt       <= '0;
        end
        default: state <= S_LEN_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_loader.sv
// Directed self-checking bench for pmem_loader.
module tb_pmem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_byte_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_reload = 1'b0;
  logic        out_byte_ready;
  logic        out_pmem_wr_en;
  logic [11:0] out_pmem_wr_addr;
  logic [15:0] out_pmem_wr_word;
  logic        out_cpu_reset;
  logic        out_done;
  logic        out_error;

  int checks = 0;
  int errors = 0;

  logic [11:0] wa [0:15];
  logic [15:0] ww [0:15];
  int          wn = 0;

  pmem_loader dut (
    .clock            (clock),
    .reset            (reset),
    .in_byte_valid    (in_byte_valid),
    .in_byte          (in_byte),
    .in_reload        (in_reload),
    .out_byte_ready   (out_byte_ready),
    .out_pmem_wr_en   (out_pmem_wr_en),
    .out_pmem_wr_addr (out_pmem_wr_addr),
    .out_pmem_wr_word (out_pmem_wr_word),
    .out_cpu_reset    (out_cpu_reset),
    .out_done         (out_done),
    .out_error        (out_error)
  );

  always #5 clock = ~clock;

  // Log every cycle in which the write strobe is high.
  always @(negedge clock) begin
    if (out_pmem_wr_en === 1'b1 && wn < 16) begin
      wa[wn] = out_pmem_wr_addr;
      ww[wn] = out_pmem_wr_word;
      wn++;
    end
  end

  // Entered and left at a negedge; returns one cycle after the byte is taken.
  task automatic send(input logic [7:0] b);
    int n;
    in_byte_valid = 1'b1;
    in_byte = b;
    n = 0;
    while (out_byte_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL send_timeout byte=%h ready=%b required 1", b, out_byte_ready);
    end
    @(negedge clock);
  endtask

  task automatic idle(input int k);
    in_byte_valid = 1'b0;
    repeat (k) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_byte_valid = 1'b0;
    in_reload = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    wn = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({out_byte_ready, out_pmem_wr_en, out_cpu_reset, out_done, out_error} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_ctrl rdy/wen/cpurst/done/err=%b required 00100",
               {out_byte_ready, out_pmem_wr_en, out_cpu_reset, out_done, out_error});
    end
    checks++;
    if (out_pmem_wr_addr !== 12'd0 || out_pmem_wr_word !== 16'd0) begin
      errors++;
      $display("FAIL reset_data addr=%h word=%h required 0 0", out_pmem_wr_addr, out_pmem_wr_word);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (out_byte_ready !== 1'b1 || out_cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_release ready=%b cpu_reset=%b required 1 1", out_byte_ready, out_cpu_reset);
    end
    wn = 0;
  endtask

  task automatic test_normal_load();
    do_reset();
    send(8'h00); send(8'h02); send(8'h12); send(8'h34);
    checks++;
    if (out_pmem_wr_en !== 1'b1 || out_pmem_wr_addr !== 12'd0 || out_pmem_wr_word !== 16'h1234) begin
      errors++;
      $display("FAIL normal_w0 wen=%b addr=%h word=%h required 1 000 1234",
               out_pmem_wr_en, out_pmem_wr_addr, out_pmem_wr_word);
    end
    send(8'hAB);
    checks++;
    if (out_pmem_wr_en !== 1'b0 || out_pmem_wr_word !== 16'h1234) begin
      errors++;
      $display("FAIL normal_pulse wen=%b word=%h required 0 1234", out_pmem_wr_en, out_pmem_wr_word);
    end
    send(8'hCD);
    checks++;
    if (out_pmem_wr_en !== 1'b1 || out_pmem_wr_addr !== 12'd2 || out_pmem_wr_word !== 16'hABCD
        || out_done !== 1'b0) begin
      errors++;
      $display("FAIL normal_w1 wen=%b addr=%h word=%h done=%b required 1 002 abcd 0",
               out_pmem_wr_en, out_pmem_wr_addr, out_pmem_wr_word, out_done);
    end
    send(8'hC0);
    checks++;
    if (out_done !== 1'b1 || out_cpu_reset !== 1'b0 || out_byte_ready !== 1'b0 || out_error !== 1'b0) begin
      errors++;
      $display("FAIL normal_release done=%b cpu_reset=%b ready=%b error=%b required 1 0 0 0",
               out_done, out_cpu_reset, out_byte_ready, out_error);
    end
    idle(3);
    checks++;
    if (wn !== 2) begin
      errors++;
      $display("FAIL normal_wcount writes=%0d required 2", wn);
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    send(8'h00); send(8'h02); send(8'h12); send(8'h34);
    send(8'hAB); send(8'hCD); send(8'hC1);
    checks++;
    if (out_error !== 1'b1 || out_cpu_reset !== 1'b1 || out_done !== 1'b0 || out_byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL badchk_state error=%b cpu_reset=%b done=%b ready=%b required 1 1 0 0",
               out_error, out_cpu_reset, out_done, out_byte_ready);
    end
    in_byte = 8'h55;
    repeat (3) @(negedge clock);
    checks++;
    if (out_byte_ready !== 1'b0 || out_error !== 1'b1) begin
      errors++;
      $display("FAIL badchk_hold ready=%b error=%b required 0 1", out_byte_ready, out_error);
    end
    idle(1);
    checks++;
    if (wn !== 2 || wa[0] !== 12'd0 || ww[0] !== 16'h1234 || wa[1] !== 12'd2 || ww[1] !== 16'hABCD) begin
      errors++;
      $display("FAIL badchk_writes n=%0d w0=%h:%h w1=%h:%h required 2 000:1234 002:abcd",
               wn, wa[0], ww[0], wa[1], ww[1]);
    end
  endtask

  task automatic test_empty_image();
    do_reset();
    send(8'h00); send(8'h00); send(8'h00);
    checks++;
    if (out_done !== 1'b1 || out_cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL empty_release done=%b cpu_reset=%b required 1 0", out_done, out_cpu_reset);
    end
    idle(2);
    checks++;
    if (wn !== 0) begin
      errors++;
      $display("FAIL empty_writes writes=%0d required 0", wn);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    send(8'h08); send(8'h01);
    checks++;
    if (out_error !== 1'b1 || out_byte_ready !== 1'b0 || out_done !== 1'b0) begin
      errors++;
      $display("FAIL oversize error=%b ready=%b done=%b required 1 0 0",
               out_error, out_byte_ready, out_done);
    end
    idle(2);
    checks++;
    if (wn !== 0) begin
      errors++;
      $display("FAIL oversize_writes writes=%0d required 0", wn);
    end
  endtask

  task automatic test_gapped_reload();
    do_reset();
    send(8'h00); idle(1); send(8'h02); idle(2); send(8'h12); idle(3);
    send(8'h34); idle(1); send(8'hAB); idle(2); send(8'hCD); idle(3);
    send(8'hC0);
    checks++;
    if (out_done !== 1'b1 || out_cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL gapped_release done=%b cpu_reset=%b required 1 0", out_done, out_cpu_reset);
    end
    idle(2);
    checks++;
    if (wn !== 2 || wa[0] !== 12'd0 || ww[0] !== 16'h1234 || wa[1] !== 12'd2 || ww[1] !== 16'hABCD) begin
      errors++;
      $display("FAIL gapped_writes n=%0d w0=%h:%h w1=%h:%h required 2 000:1234 002:abcd",
               wn, wa[0], ww[0], wa[1], ww[1]);
    end
    wn = 0;
    in_reload = 1'b1;
    @(negedge clock);
    in_reload = 1'b0;
    checks++;
    if (out_cpu_reset !== 1'b1 || out_done !== 1'b0 || out_byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL reload_state cpu_reset=%b done=%b ready=%b required 1 0 1",
               out_cpu_reset, out_done, out_byte_ready);
    end
    send(8'h00); send(8'h01); send(8'hFF); send(8'hFF); send(8'hFF);
    checks++;
    if (out_done !== 1'b1 || out_error !== 1'b0) begin
      errors++;
      $display("FAIL reload_done done=%b error=%b required 1 0", out_done, out_error);
    end
    idle(2);
    checks++;
    if (wn !== 1 || wa[0] !== 12'd0 || ww[0] !== 16'hFFFF) begin
      errors++;
      $display("FAIL reload_writes n=%0d w0=%h:%h required 1 000:ffff", wn, wa[0], ww[0]);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    send(8'h00); send(8'h01); send(8'h12);
    in_byte = 8'h34;
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({out_byte_ready, out_pmem_wr_en, out_cpu_reset, out_done, out_error} !== 5'b00100
        || out_pmem_wr_addr !== 12'd0 || out_pmem_wr_word !== 16'd0) begin
      errors++;
      $display("FAIL midreset rdy/wen/cpurst/done/err=%b addr=%h word=%h required 00100 000 0000",
               {out_byte_ready, out_pmem_wr_en, out_cpu_reset, out_done, out_error},
               out_pmem_wr_addr, out_pmem_wr_word);
    end
    reset = 1'b0;
    idle(3);
    checks++;
    if (wn !== 0) begin
      errors++;
      $display("FAIL midreset_writes writes=%0d required 0", wn);
    end
    send(8'h00); send(8'h01); send(8'h12); send(8'h34); send(8'h47);
    checks++;
    if (out_done !== 1'b1 || out_cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL midreset_reload done=%b cpu_reset=%b required 1 0", out_done, out_cpu_reset);
    end
    idle(2);
    checks++;
    if (wn !== 1 || wa[0] !== 12'd0 || ww[0] !== 16'h1234) begin
      errors++;
      $display("FAIL midreset_image n=%0d w0=%h:%h required 1 000:1234", wn, wa[0], ww[0]);
    end
  endtask

  initial begin
    test_reset();
    test_normal_load();
    test_bad_checksum();
    test_empty_image();
    test_oversize();
    test_gapped_reload();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pmem_loader.md
# pmem_loader

Program-memory loader: the write-side counterpart of the fetch stage's read-only program memory port. It receives a byte-stream program image on a valid/ready interface, assembles big-endian 16-bit instruction words and writes them into program memory at byte addresses 0, 2, 4, and so on. It holds the CPU pipeline in reset until the image has been written and its checksum has been verified. It sits beside `swt16_top` and drives its `reset` input and a program-memory write port.

## Interface
- `PMEM_ADDR_WIDTH`, 12: program-memory byte-address width.
- `PMEM_WORD_WIDTH`, 16: instruction word width. Fixed at 2 bytes.
- `PMEM_NUM_WORDS`, 2048: maximum image length in words.
- `PC_INCREMENT`, 2: address step per word.
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `in_byte_valid` in 1: `in_byte` holds a byte.
- `in_byte` in 8: stream byte.
- `in_reload` in 1: restart a load. Honoured only in DONE or ERROR.
- `out_byte_ready` in 1, out direction: loader accepts a byte. A byte transfers when valid && ready.
- `out_pmem_wr_en` out 1: one-cycle write strobe.
- `out_pmem_wr_addr` out PMEM_ADDR_WIDTH: write byte address.
- `out_pmem_wr_word` out PMEM_WORD_WIDTH: write data.
- `out_cpu_reset` out 1: drives the CPU reset.
- `out_done` out 1: image loaded and verified.
- `out_error` out 1: load failed. Sticky until `reset` or `in_reload`.

## Operation
- Image format, in stream order:
  - LEN_HI, LEN_LO: word count N, 16-bit big-endian.
  - N × (DATA_HI, DATA_LO): each word big-endian.
  - CHK: 8-bit sum mod 256 of all preceding bytes, including the length bytes.
- State machine (transitions occur only on an accepted byte unless noted):
  - S_LEN_HI → S_LEN_LO.
  - S_LEN_LO:
    - N > PMEM_NUM_WORDS → S_ERROR.
    - N == 0 → S_CHK.
    - otherwise → S_DATA_HI.
  - S_DATA_HI → S_DATA_LO.
  - S_DATA_LO: issue the write.
    - Words remaining → S_DATA_HI.
    - Last word → S_CHK.
  - S_CHK:
    - Byte equals the running sum → S_DONE.
    - Otherwise → S_ERROR.
  - S_DONE, S_ERROR: hold state. `in_reload`=1 → S_LEN_HI. This transition needs no byte.
- Running sum:
  - 8-bit; wrap-around is intentional.
  - Cleared on reset and on reload.
  - Accumulates every accepted byte except CHK.
- Word counter:
  - PMEM_ADDR_WIDTH+1 bits.
  - Cleared at the start of each load.
  - Incremented on each word write.
  - Write address = counter × PC_INCREMENT, truncated to PMEM_ADDR_WIDTH. The maximum address is 4094 with the default parameters.
- `out_byte_ready` = 1 in S_LEN_HI through S_CHK; 0 in S_DONE and S_ERROR. Bytes offered while ready=0 are not consumed.
- `out_cpu_reset`:
  - 1 in every state except S_DONE.
  - Reload re-asserts it in the cycle after `in_reload` is sampled.
- ERROR does not erase words already written.
- `in_reload` in any other state is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - `out_byte_ready`=0, `out_pmem_wr_en`=0, `out_pmem_wr_addr`=0, `out_pmem_wr_word`=0.
  - `out_cpu_reset`=1, `out_done`=0, `out_error`=0.
  - State = S_LEN_HI.
- `out_byte_ready` rises in the first cycle after `reset` deasserts.
- Full throughput: one byte per cycle.
- Write latency: `out_pmem_wr_en` pulses for exactly 1 cycle, in the cycle after DATA_LO is accepted. Address and word are valid in that cycle. Address and word hold their last value otherwise.
- Release latency: in the cycle after CHK is accepted, `out_done`=1 and `out_cpu_reset`=0. The last write always precedes release by at least 1 cycle.
- Error latency:
  - `out_error`=1 and `out_byte_ready`=0 in the cycle after the offending byte is accepted.
  - For an oversize length, the offending byte is LEN_LO.
- `reset` mid-load:
  - All outputs return to reset values in the next cycle.
  - A write in flight is dropped.
  - Partial pmem contents remain.

## Test plan
- Normal load:
  - Stimulus: stream 00 02 12 34 AB CD C0, valid held high.
  - Required: one write pulse with addr 0, word 0x1234; one write pulse with addr 2, word 0xABCD. One cycle after C0 is accepted: `out_done`=1, `out_cpu_reset`=0, `out_byte_ready`=0.
- Bad checksum:
  - Stimulus: same stream with C1 as the final byte.
  - Required: both writes occur; then `out_error`=1, `out_cpu_reset` stays 1, `out_done`=0, and a further byte is not accepted.
- Empty image:
  - Stimulus: 00 00 00.
  - Required: no write pulses; `out_done`=1 one cycle after the third byte.
- Oversize length:
  - Stimulus: 08 01, i.e. N=2049.
  - Required: `out_error`=1 one cycle after 01; no writes; ready=0.
- Gapped stream and reload:
  - Stimulus: the normal-load image with `in_byte_valid` dropping for 1–3 cycles between bytes; then pulse `in_reload` and load 00 01 FF FF FF.
  - Required: identical writes for the first image. After the reload pulse, `out_cpu_reset`=1 and `out_done`=0 the next cycle. The second image writes addr 0 with word 0xFFFF, then `out_done`=1.
- Reset mid-load:
  - Stimulus: assert `reset` in the cycle DATA_LO of word 0 is accepted.
  - Required: no write pulse; all outputs at reset values; a subsequent full image loads normally.
